// File: rtl/ptp_pkg.sv
// Shared types and framing constants for the PTP receive path.
package ptp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } rx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [3:0] NIB_PRE       = 4'h5;
    localparam logic [3:0] NIB_SFD       = 4'hD;

endpackage

// File: rtl/rgmii_nibble_pack.sv
// RGMII mode mux and 4b-to-8b packer; in 10/100 the byte phase is locked by the 5,D SFD pair.
module rgmii_nibble_pack
    import ptp_pkg::*;
(
    input  logic       rgmii_clk,
    input  logic       rst,
    input  logic       i_giga,
    input  logic       i_ctrl_r,
    input  logic       i_ctrl_f,
    input  logic [3:0] i_data_r,
    input  logic [3:0] i_data_f,
    output logic       o_dv,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_rx_er,
    output logic       o_odd
);

    logic       r_dv;
    logic       r_byte_valid;
    logic [7:0] r_byte;
    logic       r_rx_er;
    logic       r_odd;
    logic       r_aligned;
    logic       r_have_prev;
    logic [3:0] r_prev;

    always_ff @(posedge rgmii_clk or posedge rst) begin
        if (rst) begin
            r_dv         <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
            r_rx_er      <= 1'b0;
            r_odd        <= 1'b0;
            r_aligned    <= 1'b0;
            r_have_prev  <= 1'b0;
            r_prev       <= '0;
        end else begin
            r_dv         <= i_ctrl_r;
            r_byte_valid <= 1'b0;
            r_rx_er      <= 1'b0;
            r_odd        <= 1'b0;
            if (!i_ctrl_r) begin
                // a low nibble still waiting for its partner at carrier drop is a dribble nibble
                r_odd       <= r_aligned & r_have_prev;
                r_aligned   <= 1'b0;
                r_have_prev <= 1'b0;
            end else if (i_giga) begin
                r_byte_valid <= 1'b1;
                r_byte       <= {i_data_f, i_data_r};
                r_rx_er      <= i_ctrl_r ^ i_ctrl_f;
            end else if (!r_aligned) begin
                // hunting: present every sliding nibble pair so the SFD is found at either phase
                r_byte_valid <= r_have_prev;
                r_byte       <= {i_data_r, r_prev};
                r_prev       <= i_data_r;
                r_have_prev  <= 1'b1;
                if (r_have_prev && i_data_r == NIB_SFD && r_prev == NIB_PRE) begin
                    r_aligned   <= 1'b1;
                    r_have_prev <= 1'b0;
                end
            end else if (!r_have_prev) begin
                r_prev      <= i_data_r;
                r_have_prev <= 1'b1;
            end else begin
                r_byte_valid <= 1'b1;
                r_byte       <= {i_data_r, r_prev};
                r_have_prev  <= 1'b0;
            end
        end
    end

    assign o_dv         = r_dv;
    assign o_byte_valid = r_byte_valid;
    assign o_byte       = r_byte;
    assign o_rx_er      = r_rx_er;
    assign o_odd        = r_odd;

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: preamble/SFD strip, one-byte hold for eop marking, ts_req at SFD, frame statistics.
//   state | meaning
//   IDLE  | no carrier, mode follows giga_mode
//   PRE   | counting preamble, hunting for SFD
//   DATA  | frame bytes flow through the hold register
//   DROP  | bad or truncated frame, discard until carrier drops
module rgmii_rx_framer
    import ptp_pkg::*;
#(
    parameter int MAX_PRE = 15,
    parameter int MAX_LEN = 2047,
    parameter int CNT_W   = 16
) (
    input  logic             rgmii_clk,
    input  logic             rst,
    input  logic             giga_mode,
    input  logic             rgmii_ctrl_r,
    input  logic             rgmii_ctrl_f,
    input  logic [3:0]       rgmii_data_r,
    input  logic [3:0]       rgmii_data_f,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             rx_sop,
    output logic             rx_eop,
    output logic             rx_err,
    output logic             ts_req,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int PRE_W = $clog2(2 * MAX_PRE + 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
    // 10/100 hunting sees one sliding pair per nibble, so the limit is counted in nibbles there
    localparam logic [PRE_W-1:0] PRE_LIM_G = PRE_W'(MAX_PRE);
    localparam logic [PRE_W-1:0] PRE_LIM_S = PRE_W'(2 * MAX_PRE);

    rx_state_t        r_state;
    logic             r_giga;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [LEN_W-1:0] r_len;
    logic [7:0]       r_hold;
    logic             r_hold_full;
    logic             r_first;
    logic             r_err_acc;
    logic             r_rx_valid;
    logic [7:0]       r_rx_data;
    logic             r_rx_sop;
    logic             r_rx_eop;
    logic             r_rx_err;
    logic             r_ts_req;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_dv;
    logic             w_bv;
    logic [7:0]       w_byte;
    logic             w_rx_er;
    logic             w_odd;
    logic             w_giga;
    logic [PRE_W-1:0] w_pre_cnt;
    logic [PRE_W-1:0] w_pre_lim;
    logic             w_end_err;

    assign w_giga    = (r_state == IDLE && !w_dv) ? giga_mode : r_giga;
    assign w_pre_cnt = (r_state == IDLE) ? '0 : r_pre_cnt;
    assign w_pre_lim = r_giga ? PRE_LIM_G : PRE_LIM_S;
    assign w_end_err = r_err_acc | w_odd;

    rgmii_nibble_pack u_pack (
        .rgmii_clk    (rgmii_clk),
        .rst          (rst),
        .i_giga       (w_giga),
        .i_ctrl_r     (rgmii_ctrl_r),
        .i_ctrl_f     (rgmii_ctrl_f),
        .i_data_r     (rgmii_data_r),
        .i_data_f     (rgmii_data_f),
        .o_dv         (w_dv),
        .o_byte_valid (w_bv),
        .o_byte       (w_byte),
        .o_rx_er      (w_rx_er),
        .o_odd        (w_odd)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge rgmii_clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_giga      <= 1'b0;
            r_pre_cnt   <= '0;
            r_len       <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_first     <= 1'b0;
            r_err_acc   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= '0;
            r_rx_sop    <= 1'b0;
            r_rx_eop    <= 1'b0;
            r_rx_err    <= 1'b0;
            r_ts_req    <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_sop   <= 1'b0;
            r_rx_eop   <= 1'b0;
            r_rx_err   <= 1'b0;
            r_ts_req   <= 1'b0;
            if (r_state == IDLE && !w_dv) r_giga <= giga_mode;
            case (r_state)
                IDLE, PRE: begin
                    if (!w_dv) begin
                        r_state   <= IDLE;
                        r_pre_cnt <= '0;
                    end else if (!w_bv) begin
                        r_state   <= PRE;
                        r_pre_cnt <= w_pre_cnt;
                    end else if (w_byte == SFD_BYTE) begin
                        r_state     <= DATA;
                        r_ts_req    <= 1'b1;
                        r_hold_full <= 1'b0;
                        r_first     <= 1'b1;
                        r_len       <= '0;
                        r_err_acc   <= 1'b0;
                    end else if (w_byte == PREAMBLE_BYTE && w_pre_cnt < w_pre_lim) begin
                        r_state   <= PRE;
                        r_pre_cnt <= w_pre_cnt + 1'b1;
                    end else begin
                        r_state   <= DROP;
                        r_err_cnt <= sat_inc(r_err_cnt);
                    end
                end
                DATA: begin
                    if (!w_dv) begin
                        r_state <= IDLE;
                        if (r_hold_full) begin
                            r_rx_valid  <= 1'b1;
                            r_rx_data   <= r_hold;
                            r_rx_sop    <= r_first;
                            r_rx_eop    <= 1'b1;
                            r_rx_err    <= w_end_err;
                            r_frame_cnt <= sat_inc(r_frame_cnt);
                            if (w_end_err) r_err_cnt <= sat_inc(r_err_cnt);
                        end else begin
                            r_err_cnt <= sat_inc(r_err_cnt);
                        end
                    end else begin
                        if (w_rx_er) r_err_acc <= 1'b1;
                        if (w_bv) begin
                            if (r_len == LEN_MAX) begin
                                r_rx_valid  <= 1'b1;
                                r_rx_data   <= r_hold;
                                r_rx_sop    <= r_first;
                                r_rx_eop    <= 1'b1;
                                r_rx_err    <= 1'b1;
                                r_frame_cnt <= sat_inc(r_frame_cnt);
                                r_err_cnt   <= sat_inc(r_err_cnt);
                                r_state     <= DROP;
                            end else begin
                                r_hold      <= w_byte;
                                r_hold_full <= 1'b1;
                                r_len       <= r_len + 1'b1;
                                if (r_hold_full) begin
                                    r_rx_valid <= 1'b1;
                                    r_rx_data  <= r_hold;
                                    r_rx_sop   <= r_first;
                                    r_first    <= 1'b0;
                                end
                            end
                        end
                    end
                end
                DROP: begin
                    if (!w_dv) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign rx_sop    = r_rx_sop;
    assign rx_eop    = r_rx_eop;
    assign rx_err    = r_rx_err;
    assign ts_req    = r_ts_req;
    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Scoreboard bench: a default-length framer and a MAX_LEN=16 framer fed the same RGMII stream.
module tb_rgmii_rx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       giga_mode;
    logic       ctrl_r, ctrl_f;
    logic [3:0] data_r, data_f;

    logic        a_valid, a_sop, a_eop, a_err, a_ts;
    logic [7:0]  a_data;
    logic [15:0] a_fc, a_ec;
    logic        t_valid, t_sop, t_eop, t_err, t_ts;
    logic [7:0]  t_data;
    logic [15:0] t_fc, t_ec;

    int n_checks = 0;
    int n_errors = 0;
    int a_ts_n = 0, t_ts_n = 0;
    int exp_ts = 0;
    int exp_fc_a = 0, exp_ec_a = 0, exp_fc_t = 0, exp_ec_t = 0;

    logic [10:0] qa[$];
    logic [10:0] qt[$];
    logic [7:0]  pl[$];

    always #5 clk = ~clk;

    rgmii_rx_framer dut_a (
        .rgmii_clk(clk), .rst(rst), .giga_mode(giga_mode),
        .rgmii_ctrl_r(ctrl_r), .rgmii_ctrl_f(ctrl_f),
        .rgmii_data_r(data_r), .rgmii_data_f(data_f),
        .rx_valid(a_valid), .rx_data(a_data), .rx_sop(a_sop), .rx_eop(a_eop),
        .rx_err(a_err), .ts_req(a_ts), .frame_cnt(a_fc), .err_cnt(a_ec)
    );

    rgmii_rx_framer #(.MAX_LEN(16)) dut_t (
        .rgmii_clk(clk), .rst(rst), .giga_mode(giga_mode),
        .rgmii_ctrl_r(ctrl_r), .rgmii_ctrl_f(ctrl_f),
        .rgmii_data_r(data_r), .rgmii_data_f(data_f),
        .rx_valid(t_valid), .rx_data(t_data), .rx_sop(t_sop), .rx_eop(t_eop),
        .rx_err(t_err), .ts_req(t_ts), .frame_cnt(t_fc), .err_cnt(t_ec)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (a_ts) a_ts_n++;
            if (a_valid) begin
                if (qa.size() == 0) check("a_unexpected_valid", 32'(a_valid), 32'(0));
                else check("a_byte", 32'({a_sop, a_eop, a_err, a_data}), 32'(qa.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (t_ts) t_ts_n++;
            if (t_valid) begin
                if (qt.size() == 0) check("t_unexpected_valid", 32'(t_valid), 32'(0));
                else check("t_byte", 32'({t_sop, t_eop, t_err, t_data}), 32'(qt.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ctrl_r = 1'b0; ctrl_f = 1'b0; data_r = 4'h0; data_f = 4'h0;
            tick();
        end
    endtask

    task automatic gbyte(input logic [7:0] b, input bit er);
        ctrl_r = 1'b1; ctrl_f = ~er; data_r = b[3:0]; data_f = b[7:4];
        tick();
    endtask

    task automatic snib(input logic [3:0] n);
        ctrl_r = 1'b1; ctrl_f = 1'b1; data_r = n; data_f = 4'h0;
        tick();
    endtask

    // expected output of both framers for the payload in pl; bad = RX_ER or dribble nibble
    task automatic expect_frame(input bit bad);
        int n, nt;
        bit trunc;
        n = pl.size();
        nt = (n > 16) ? 16 : n;
        trunc = (n > 16);
        for (int i = 0; i < n; i++)
            qa.push_back({i == 0, i == n - 1, (i == n - 1) && bad, pl[i]});
        for (int i = 0; i < nt; i++)
            qt.push_back({i == 0, i == nt - 1, (i == nt - 1) && (bad || trunc), pl[i]});
        exp_ts++;
        exp_fc_a++;
        exp_fc_t++;
        if (bad) exp_ec_a++;
        if (bad || trunc) exp_ec_t++;
    endtask

    task automatic giga_frame(input int npre, input int er_at);
        giga_mode = 1'b1;
        idle(2);
        for (int i = 0; i < npre; i++) gbyte(8'h55, 1'b0);
        gbyte(8'hD5, 1'b0);
        for (int i = 0; i < pl.size(); i++) gbyte(pl[i], i == er_at);
        idle(1);
    endtask

    task automatic sdr_frame(input int npre, input bit odd);
        giga_mode = 1'b0;
        idle(2);
        for (int i = 0; i < npre; i++) snib(4'h5);
        snib(4'hD);
        for (int i = 0; i < pl.size(); i++) begin
            snib(pl[i][3:0]);
            snib(pl[i][7:4]);
        end
        if (odd) snib(4'h9);
        idle(1);
    endtask

    task automatic end_checks(input string tag);
        idle(6);
        check({tag, "_qa_left"}, 32'(qa.size()), 32'(0));
        check({tag, "_qt_left"}, 32'(qt.size()), 32'(0));
        check({tag, "_a_frame_cnt"}, 32'(a_fc), 32'(exp_fc_a));
        check({tag, "_a_err_cnt"}, 32'(a_ec), 32'(exp_ec_a));
        check({tag, "_t_frame_cnt"}, 32'(t_fc), 32'(exp_fc_t));
        check({tag, "_t_err_cnt"}, 32'(t_ec), 32'(exp_ec_t));
        check({tag, "_a_ts_cnt"}, 32'(a_ts_n), 32'(exp_ts));
        check({tag, "_t_ts_cnt"}, 32'(t_ts_n), 32'(exp_ts));
    endtask

    initial begin
        rst = 1'b1;
        giga_mode = 1'b1;
        ctrl_r = 1'b0; ctrl_f = 1'b0; data_r = 4'h0; data_f = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'({a_valid, a_sop, a_eop, a_err, a_ts, a_data}), 32'(0));
        check("rst_counters", 32'({a_fc, a_ec}), 32'(0));
        rst = 1'b0;
        idle(2);

        // giga, 64-byte clean frame
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(i));
        expect_frame(1'b0);
        giga_frame(7, -1);
        end_checks("giga64");

        // 100M, odd preamble-nibble count tolerance via 15 fives
        pl.delete();
        pl.push_back(8'hA7);
        pl.push_back(8'h3C);
        expect_frame(1'b0);
        sdr_frame(15, 1'b0);
        end_checks("sdr2");

        // 100M, 14 fives (odd phase) and a dribble nibble at the end
        pl.delete();
        pl.push_back(8'h12);
        pl.push_back(8'h34);
        expect_frame(1'b1);
        sdr_frame(14, 1'b1);
        end_checks("sdr_odd");

        // giga, RX_ER in mid-frame
        pl.delete();
        for (int i = 0; i < 6; i++) pl.push_back(8'hC0 + 8'(i));
        expect_frame(1'b1);
        giga_frame(7, 3);
        end_checks("giga_er");

        // giga, bad preamble byte: dropped, no ts_req
        giga_mode = 1'b1;
        idle(2);
        gbyte(8'h55, 1'b0);
        gbyte(8'h55, 1'b0);
        gbyte(8'h57, 1'b0);
        gbyte(8'hD5, 1'b0);
        gbyte(8'h11, 1'b0);
        gbyte(8'h22, 1'b0);
        idle(1);
        exp_ec_a++;
        exp_ec_t++;
        end_checks("bad_pre");

        // giga, 20-byte payload: truncated on the MAX_LEN=16 framer
        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'h80 + 8'(i));
        expect_frame(1'b0);
        giga_frame(7, -1);
        end_checks("trunc");

        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom_range(0, 255)));
        expect_frame(1'b0);
        giga_frame(3, -1);
        end_checks("after_trunc");

        // reset in the middle of DATA
        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'h40 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            qa.push_back({i == 0, 1'b0, 1'b0, pl[i]});
            qt.push_back({i == 0, 1'b0, 1'b0, pl[i]});
        end
        giga_mode = 1'b1;
        idle(2);
        for (int i = 0; i < 7; i++) gbyte(8'h55, 1'b0);
        gbyte(8'hD5, 1'b0);
        for (int i = 0; i < 10; i++) gbyte(pl[i], 1'b0);
        rst = 1'b1;
        ctrl_r = 1'b0; ctrl_f = 1'b0;
        #1;
        check("midrst_outputs", 32'({a_valid, a_sop, a_eop, a_err, a_ts, a_data}), 32'(0));
        check("midrst_counters", 32'({a_fc, a_ec, t_fc[0], t_ec[0]}), 32'(0));
        qa.delete();
        qt.delete();
        exp_ts = 0; a_ts_n = 0; t_ts_n = 0;
        exp_fc_a = 0; exp_ec_a = 0; exp_fc_t = 0; exp_ec_t = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(8'hF0 ^ 8'(i * 3));
        expect_frame(1'b0);
        giga_frame(7, -1);
        end_checks("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
